// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Holds the word width, the canonical NOP, the fetch FSM encoding and the target-alignment helper.
package riscv_fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RV_NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // No misalignment trap: the low two bits of a target are simply dropped.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] target);
        return target & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/riscv_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests, holds one instruction for decode.
// Latency: 3 cycles per instruction with a gnt-now/rvalid-next memory; o_instrF is registered.
// Backpressure: i_hazard_stallF holds the fetched instruction; i_redirectE overrides the stall in every state.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_hazard_stallF,
    input  logic            i_redirectE,
    input  logic [XLEN-1:0] i_PCTargetE,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instrF,
    output logic [XLEN-1:0] o_PCF,
    output logic [XLEN-1:0] o_PCPlus4F,
    output logic            o_instr_validF,
    output logic            o_fetch_busyF
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            drop_q, drop_d;
    logic            req_raw;
    logic [XLEN-1:0] target;

    assign target = align_target(i_PCTargetE);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= RV_NOP;
            drop_q  <= 1'b0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        instr_d = instr_q;
        drop_d  = drop_q;
        req_raw = 1'b0;
        case (state)
            S_REQ: begin
                req_raw = !i_redirectE;
                if (i_redirectE) begin
                    pc_d = target;
                end else if (i_imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    // A response to a redirected-away PC is thrown away exactly once.
                    if (i_redirectE || drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (i_redirectE) begin
                            pc_d = target;
                        end
                    end else begin
                        instr_d = i_imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (i_redirectE) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (i_redirectE) begin
                    pc_d    = target;
                    instr_d = RV_NOP;
                    state_d = S_REQ;
                end else if (!i_hazard_stallF) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Request is masked during reset because the FSM already sits in S_REQ.
    assign o_imem_req     = req_raw & i_rstn;
    assign o_imem_addr    = pc_q;
    assign o_instr_validF = (state == S_HOLD);
    assign o_fetch_busyF  = !o_instr_validF;
    assign o_instrF       = o_instr_validF ? instr_q : RV_NOP;
    assign o_PCF          = pc_q;
    assign o_PCPlus4F     = pc_q + XLEN'(4);

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: reset, streaming, stall, redirects, PC wrap and mid-transaction reset.
module tb_riscv_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: RESET_PC = 0
    logic        rstn, stall, redirect, gnt, rvalid;
    logic [31:0] target, rdata;
    logic        req;
    logic [31:0] addr, instr, pcf, pcp4;
    logic        valid, busy;

    // Instance B: RESET_PC = 0xFFFF_FFFC
    logic        rstn_b, gnt_b, rvalid_b;
    logic [31:0] rdata_b;
    logic        req_b;
    logic [31:0] addr_b, instr_b, pcf_b, pcp4_b;
    logic        valid_b, busy_b;

    riscv_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .i_clk(clk), .i_rstn(rstn), .i_hazard_stallF(stall), .i_redirectE(redirect),
        .i_PCTargetE(target), .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_instrF(instr), .o_PCF(pcf),
        .o_PCPlus4F(pcp4), .o_instr_validF(valid), .o_fetch_busyF(busy)
    );

    riscv_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .i_clk(clk), .i_rstn(rstn_b), .i_hazard_stallF(1'b0), .i_redirectE(1'b0),
        .i_PCTargetE(32'h0), .o_imem_req(req_b), .o_imem_addr(addr_b), .i_imem_gnt(gnt_b),
        .i_imem_rvalid(rvalid_b), .i_imem_rdata(rdata_b), .o_instrF(instr_b), .o_PCF(pcf_b),
        .o_PCPlus4F(pcp4_b), .o_instr_validF(valid_b), .o_fetch_busyF(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in S_REQ; leaves the DUT in S_HOLD holding `word` for PC `pc`.
    task automatic fetch_one(input logic [31:0] pc, input logic [31:0] word);
        chk("req_issue", {31'b0, req}, 32'd1);
        chk("req_addr", addr, pc);
        gnt = 1'b1;
        step();
        chk("wait_req", {31'b0, req}, 32'd0);
        chk("wait_valid", {31'b0, valid}, 32'd0);
        chk("wait_instr", instr, NOP);
        rvalid = 1'b1;
        rdata  = word;
        step();
        rvalid = 1'b0;
        rdata  = 32'hBAD0_BAD0;
        chk("hold_valid", {31'b0, valid}, 32'd1);
        chk("hold_busy", {31'b0, busy}, 32'd0);
        chk("hold_instr", instr, word);
        chk("hold_pc", pcf, pc);
        chk("hold_pc4", pcp4, pc + 32'd4);
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b0; redirect = 1'b0; target = 32'h0;
        gnt = 1'b1; rvalid = 1'b0; rdata = 32'h0;
        rstn_b = 1'b0; gnt_b = 1'b1; rvalid_b = 1'b0; rdata_b = 32'h0;

        // Reset state
        repeat (2) step();
        chk("rst_req", {31'b0, req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pcf, 32'h0);
        chk("rst_pc4", pcp4, 32'h4);
        rstn = 1'b1;
        #1;

        // Streaming with a 1-cycle memory: 0, 4, 8
        fetch_one(32'h0, 32'h0010_0093);
        step();
        fetch_one(32'h4, 32'h0020_0113);
        step();
        fetch_one(32'h8, 32'h0030_0193);

        // Stall in S_HOLD at PC 8 for 4 cycles
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", {31'b0, valid}, 32'd1);
            chk("stall_instr", instr, 32'h0030_0193);
            chk("stall_pc", pcf, 32'h8);
            chk("stall_req", {31'b0, req}, 32'd0);
        end
        stall = 1'b0;
        step();
        chk("after_stall_req", {31'b0, req}, 32'd1);
        chk("after_stall_addr", addr, 32'hC);

        // Redirect while the request at 12 is outstanding; low target bits discarded
        step();
        redirect = 1'b1;
        target   = 32'h0000_0103;
        #1;
        chk("wait_redir_req", {31'b0, req}, 32'd0);
        step();
        redirect = 1'b0;
        chk("wait_redir_pc", pcf, 32'h100);
        chk("wait_redir_valid", {31'b0, valid}, 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk("dropped_valid", {31'b0, valid}, 32'd0);
        chk("dropped_instr", instr, NOP);
        fetch_one(32'h100, 32'h0040_0213);

        // Two redirects in S_WAIT: only one response is dropped
        step();
        chk("seq_addr", addr, 32'h104);
        step();
        redirect = 1'b1;
        target   = 32'h200;
        step();
        target   = 32'h300;
        step();
        redirect = 1'b0;
        chk("double_redir_pc", pcf, 32'h300);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk("double_drop_valid", {31'b0, valid}, 32'd0);
        fetch_one(32'h300, 32'h0050_0293);

        // Redirect and stall together in S_HOLD: redirect wins
        stall    = 1'b1;
        redirect = 1'b1;
        target   = 32'h40;
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        chk("hold_redir_valid", {31'b0, valid}, 32'd0);
        chk("hold_redir_instr", instr, NOP);
        chk("hold_redir_addr", addr, 32'h40);
        chk("hold_redir_req", {31'b0, req}, 32'd1);

        // Redirect in S_REQ suppresses the request combinationally
        redirect = 1'b1;
        target   = 32'h80;
        #1;
        chk("req_redir_req", {31'b0, req}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        chk("req_redir_addr", addr, 32'h80);
        chk("req_redir_req_after", {31'b0, req}, 32'd1);

        // Reset asserted in S_WAIT
        step();
        chk("pre_rst_pc", pcf, 32'h80);
        rstn = 1'b0;
        #1;
        chk("midrst_req", {31'b0, req}, 32'd0);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_pc", pcf, 32'h0);
        step();
        rstn = 1'b1;
        #1;
        fetch_one(32'h0, 32'h0010_0093);

        // PC wrap on the second instance
        rstn_b = 1'b1;
        #1;
        chk("wrap_req", {31'b0, req_b}, 32'd1);
        chk("wrap_addr0", addr_b, 32'hFFFF_FFFC);
        step();
        rvalid_b = 1'b1;
        rdata_b  = 32'h0060_0313;
        step();
        rvalid_b = 1'b0;
        chk("wrap_valid", {31'b0, valid_b}, 32'd1);
        chk("wrap_pc", pcf_b, 32'hFFFF_FFFC);
        chk("wrap_pc4", pcp4_b, 32'h0);
        chk("wrap_instr", instr_b, 32'h0060_0313);
        step();
        chk("wrap_addr1", addr_b, 32'h0);
        chk("wrap_req1", {31'b0, req_b}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction-fetch stage of the pipelined RV32I core, directly upstream of the decode stage. Owns the program counter and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Redirects from execute (taken branch, jal, jalr) and stalls from the hazard unit are applied here. The stage presents `o_instrF`, `o_PCF` and `o_PCPlus4F` to the decode pipeline register, and drives a NOP whenever no valid instruction is held.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC fetched first after reset.
- `i_clk`, input, 1: clock; all state updates on rising edge.
- `i_rstn`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_hazard_stallF`, input, 1: decode cannot accept this cycle; hold the current instruction.
- `i_redirectE`, input, 1: control transfer resolved in execute.
- `i_PCTargetE`, input, `XLEN`: redirect target. Bits [1:0] are forced to 00.
- `o_imem_req`, output, 1: fetch request valid.
- `o_imem_addr`, output, `XLEN`: request address, equal to the PC.
- `i_imem_gnt`, input, 1: request accepted this cycle.
- `i_imem_rvalid`, input, 1: response data valid.
- `i_imem_rdata`, input, `XLEN`: response instruction word.
- `o_instrF`, output, `XLEN`: instruction to decode. Equals NOP (`32'h0000_0013`) when not valid.
- `o_PCF`, output, `XLEN`: PC of the instruction.
- `o_PCPlus4F`, output, `XLEN`: `o_PCF + 4`, modulo 2^32.
- `o_instr_validF`, output, 1: `o_instrF` holds a real fetched instruction.
- `o_fetch_busyF`, output, 1: the inverse of `o_instr_validF`. Used by the hazard unit for bubble accounting.

## Operation
Internal state:
- `pc_q`: the PC register.
- `instr_q`: the held instruction.
- `drop_q`: set when an in-flight response must be discarded.
- `state`: one of `S_REQ`, `S_WAIT`, `S_HOLD`.

Reset values:
- `state = S_REQ`, `pc_q = RESET_PC`, `drop_q = 0`, `instr_q = NOP`.
- Outputs: `o_imem_req = 0` while `i_rstn` is low, `o_instrF = NOP`, `o_PCF = RESET_PC`, `o_PCPlus4F = RESET_PC + 4`, `o_instr_validF = 0`, `o_fetch_busyF = 1`.

State behaviour:
- **`S_REQ`**
  - `o_imem_req = !i_redirectE`; `o_imem_addr = pc_q`.
  - If redirect: `pc_q <= target`, stay in `S_REQ`.
  - Else if `i_imem_gnt`: go to `S_WAIT`.
- **`S_WAIT`**
  - `o_imem_req = 0`.
  - Redirect without rvalid: `pc_q <= target`, `drop_q <= 1`, stay in `S_WAIT`.
  - rvalid with redirect, or rvalid with `drop_q = 1`: discard the data, clear `drop_q`, apply the redirect to `pc_q` if present, go to `S_REQ`.
  - rvalid otherwise: `instr_q <= i_imem_rdata`, go to `S_HOLD`.
- **`S_HOLD`**
  - `o_instr_validF = 1`; `o_instrF = instr_q`.
  - Redirect: discard `instr_q`, `pc_q <= target`, go to `S_REQ`.
  - Else if `!i_hazard_stallF`: the instruction is consumed by decode; `pc_q <= pc_q + 4`, go to `S_REQ`.
  - Else: hold all state.

Priority and boundary rules:
- Redirect beats stall in every state.
- `i_imem_rvalid` is ignored outside `S_WAIT`.
- `i_imem_gnt` is ignored when `o_imem_req = 0`.
- Consecutive redirects while in `S_WAIT` overwrite `pc_q`; `drop_q` stays set. Exactly one response is dropped.
- PC increment wraps: `32'hFFFF_FFFC + 4 = 0`.
- Reset asserted mid-transaction returns the block to reset state immediately. The instruction memory is reset on the same `i_rstn`, so no stale response survives.
- There is no misalignment trap; target bits [1:0] are discarded.

## Timing
- With a memory that grants and responds in minimum time (gnt in the request cycle, rvalid the next cycle), each instruction takes 3 cycles: `S_REQ` → `S_WAIT` → `S_HOLD`.
- `o_instrF` is registered. It becomes valid the cycle after `i_imem_rvalid`.
- A redirect takes effect on `o_imem_addr` in the next cycle.
- `o_PCF` and `o_PCPlus4F` follow `pc_q` combinationally. No output depends on `i_imem_rdata` combinationally.
- `o_imem_req` depends combinationally on `i_redirectE`.

## Structure
- Add to `riscv_configs.v`:
  - `` `RV_NOP`` (`32'h0000_0013`).
  - `` `FETCH_S_REQ``, `` `FETCH_S_WAIT``, `` `FETCH_S_HOLD`` (2-bit encodings).
- `XLEN` comes from the same header.
- The block is a single module, with the FSM, PC register and +4 adder inline. No sub-module is needed.

## Test plan
- **Reset, 1-cycle memory:** release `i_rstn` with a 1-cycle latency memory. Expect `o_imem_addr` = 0, 4, 8. Expect `o_instr_validF` high every third cycle, with `o_PCF` matching each address and `o_instrF` equal to the memory word.
- **Stall:** assert `i_hazard_stallF` for 4 cycles while in `S_HOLD` with PC=8. Expect `o_instrF` and `o_PCF` held for 4 cycles, then the next request at 12.
- **Redirect in `S_WAIT`:** redirect to `0x100` while the request at 4 is outstanding. Expect the response for 4 to be dropped, then a request to `0x100`, then a valid instruction with `o_PCF = 0x100`.
- **Redirect in `S_HOLD` with stall:** assert `i_redirectE` and `i_hazard_stallF` together in `S_HOLD`. Expect the redirect to win: the held instruction is discarded, `o_imem_addr` = target next cycle, and `o_instrF` = NOP.
- **PC wrap:** set `RESET_PC = 32'hFFFF_FFFC` and fetch two instructions. Expect the second fetch at address 0 and `o_PCPlus4F = 0` for the first.
- **Reset mid-transaction:** assert `i_rstn` low during `S_WAIT`. Expect `o_imem_req` = 0, `o_instr_validF` = 0, `o_PCF = RESET_PC` immediately, and a clean restart at `RESET_PC` after release.
